// File: rtl/fetch_stage.sv
// fetch_stage: RV32I program counter with execute redirect and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount
);
    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next;
    assign pc_plus4_f = PCF + 32'd4;
    assign pc_next = PCSrcE ? {PCTargetE[31:2], 2'b00} : StallF ? PCF : pc_plus4_f;
    always_ff @(posedge clk) begin
        if (rst) begin
            PCF        <= RESET_PC;
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
            FetchCount <= '0;
        end else begin
            PCF <= pc_next;
            if (FlushD) begin
                InstrD   <= NOP_INSTR;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else if (!StallD) begin
                InstrD     <= InstrF;
                PCD        <= PCF;
                PCPlus4D   <= pc_plus4_f;
                ValidD     <= 1'b1;
                FetchCount <= FetchCount + 32'd1;
            end
        end
    end
endmodule
